// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types and helpers for the binary processing unit array.
//   bpu_state_e : pass sequencer states (idle, row sweep, result held)
//   row_term()  : signed XNOR-popcount of one kernel row, +1 per matching bit,
//                 -1 per mismatching bit (2*popcount(~(a^b)) - k)
package bpu_pkg;

    typedef enum logic [1:0] {
        BPU_IDLE,
        BPU_RUN,
        BPU_DONE
    } bpu_state_e;

    // Widest kernel row the helper accepts; callers zero-extend to this width.
    localparam int unsigned MAX_K = 32;

    function automatic int row_term(input logic [MAX_K-1:0] win,
                                    input logic [MAX_K-1:0] wgt,
                                    input int               k);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_K; i++) begin
            if ((i < k) && (win[i] == wgt[i])) begin
                cnt++;
            end
        end
        return 2 * cnt - k;
    endfunction

endpackage

// File: rtl/bpu_lane.sv
// bpu_lane: one output lane of the BPU array.
//   Holds a K-row binary kernel written through a wrapping row pointer, and a
//   signed ACC_W-bit accumulator that adds one row term per cycle while 'add'.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en          : clock enable, all state holds when low
//   wgt_wr      : store wgt_row at the row pointer, then advance the pointer
//   wgt_row     : kernel row data
//   clr         : clear the accumulator (fresh pass)
//   add         : accumulate row term of win against kernel row row_sel
//   row_sel     : kernel row used for the current add
//   win         : image window row for the current add
//   result      : accumulator value
// Build option: BPU_ARRAY_SAT_EN saturates each add; otherwise it wraps.
module bpu_lane
    import bpu_pkg::*;
#(
    parameter int unsigned K     = 7,
    parameter int unsigned ACC_W = 12,
    localparam int unsigned ROW_W = (K > 1) ? $clog2(K) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wgt_wr,
    input  logic [K-1:0]            wgt_row,
    input  logic                    clr,
    input  logic                    add,
    input  logic [ROW_W-1:0]        row_sel,
    input  logic [K-1:0]            win,
    output logic signed [ACC_W-1:0] result
);

    // Headroom for one row term on top of a full-scale accumulator.
    localparam int unsigned SUM_W = ACC_W + 8;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(K - 1);

    logic [K-1:0]            wgt_q [K];
    logic [ROW_W-1:0]        ptr_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        sum = SUM_W'(acc_q)
            + SUM_W'(row_term(MAX_K'(win), MAX_K'(wgt_q[row_sel]), int'(K)));
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
`ifdef BPU_ARRAY_SAT_EN
            if (sum > SUM_W'(ACC_MAX)) begin
                acc_d = ACC_MAX;
            end else if (sum < SUM_W'(ACC_MIN)) begin
                acc_d = ACC_MIN;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
`else
            acc_d = sum[ACC_W-1:0];
`endif
        end
    end

`ifndef BPU_ARRAY_SAT_EN
    // Wrapping add drops the headroom bits.
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[SUM_W-1:ACC_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                wgt_q[i] <= '0;
            end
            ptr_q <= '0;
            acc_q <= '0;
        end else if (en) begin
            if (wgt_wr) begin
                wgt_q[ptr_q] <= wgt_row;
                ptr_q        <= (ptr_q == ROW_LAST) ? '0 : ptr_q + 1'b1;
            end
            acc_q <= acc_d;
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/bpu_array.sv
// bpu_array: binary processing unit array for the BNN processor.
//   A shared IMG_ROWS x IMG_W bit image buffer feeds N_LANE lanes, each with a
//   KxK binary kernel. 'start' launches a K-cycle row sweep; every lane adds a
//   signed XNOR-popcount term per row, then the result is held until accepted.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   en                 : clock enable, all state holds when low
//   data_in            : image column bits (img_wr) or kernel row (wgt_wr)
//   img_wr, img_bank   : shift data_in[i] into row img_bank*DIN_W+i
//   img_up             : shift buffer up one row (row r <= row r+1, top <= 0)
//   wgt_wr, wgt_lane   : write one kernel row to lane wgt_lane
//   start, acc, ofs    : begin a pass; acc=1 keeps the previous result,
//                        ofs selects the window column offset
//   out_ready          : consumer accepts the held result
//   out_valid, busy    : result held / pass in progress
//   result             : per-lane signed result
// Build option: BPU_ARRAY_SAT_EN selects saturating accumulation.
module bpu_array
    import bpu_pkg::*;
#(
    parameter int unsigned N_LANE   = 8,
    parameter int unsigned K        = 7,
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned IMG_ROWS = 16,
    parameter int unsigned DIN_W    = 8,
    parameter int unsigned ACC_W    = 12,
    localparam int unsigned N_BANK  = IMG_ROWS / DIN_W,
    localparam int unsigned BANK_W  = (N_BANK > 1) ? $clog2(N_BANK) : 1,
    localparam int unsigned LANE_W  = (N_LANE > 1) ? $clog2(N_LANE) : 1,
    localparam int unsigned OFS_W   = (IMG_W - K + 1 > 1) ? $clog2(IMG_W - K + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DIN_W-1:0]        data_in,
    input  logic                    img_wr,
    input  logic [BANK_W-1:0]       img_bank,
    input  logic                    img_up,
    input  logic                    wgt_wr,
    input  logic [LANE_W-1:0]       wgt_lane,
    input  logic                    start,
    input  logic                    acc,
    input  logic [OFS_W-1:0]        ofs,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic                    busy,
    output logic signed [ACC_W-1:0] result [N_LANE]
);

    localparam int unsigned ROW_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned IMG_AW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam logic [OFS_W-1:0] OFS_MAX  = OFS_W'(IMG_W - K);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(K - 1);

    bpu_state_e       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [OFS_W-1:0] ofs_q, ofs_d;
    logic [IMG_W-1:0] img_q [IMG_ROWS];
    logic [IMG_W-1:0] img_d [IMG_ROWS];
    logic [IMG_W-1:0] img_row;
    logic [K-1:0]     win;
    logic             idle, run;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BPU_IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BPU_IDLE: if (start)              state_d = BPU_RUN;
            BPU_RUN:  if (row_q == ROW_LAST)  state_d = BPU_DONE;
            BPU_DONE: if (out_ready)          state_d = BPU_IDLE;
            default:                          state_d = BPU_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        idle      = (state_q == BPU_IDLE);
        run       = (state_q == BPU_RUN);
        busy      = (state_q != BPU_IDLE);
        out_valid = (state_q == BPU_DONE);
    end

    // ---------------- Row counter and window offset ----------------
    always_comb begin
        row_d = row_q;
        ofs_d = ofs_q;
        if (idle && start) begin
            row_d = '0;
            ofs_d = (ofs > OFS_MAX) ? OFS_MAX : ofs;
        end else if (run) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            ofs_q <= '0;
        end else if (en) begin
            row_q <= row_d;
            ofs_q <= ofs_d;
        end
    end

    // ---------------- Image buffer ----------------
    // Column write wins over row shift; both are frozen while a pass runs.
    always_comb begin
        for (int r = 0; r < IMG_ROWS; r++) begin
            img_d[r] = img_q[r];
        end
        if (idle) begin
            if (img_wr) begin
                for (int r = 0; r < IMG_ROWS; r++) begin
                    if (r / int'(DIN_W) == int'(img_bank)) begin
                        img_d[r] = {img_q[r][IMG_W-2:0], data_in[r % DIN_W]};
                    end
                end
            end else if (img_up) begin
                for (int r = 0; r < IMG_ROWS - 1; r++) begin
                    img_d[r] = img_q[r + 1];
                end
                img_d[IMG_ROWS-1] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < IMG_ROWS; r++) begin
                img_q[r] <= '0;
            end
        end else if (en) begin
            for (int r = 0; r < IMG_ROWS; r++) begin
                img_q[r] <= img_d[r];
            end
        end
    end

    // Window row: bits [ofs+K-1:ofs] of image row 'row_q'.
    always_comb begin
        img_row = img_q[IMG_AW'(row_q)];
        win     = K'(img_row >> ofs_q);
    end

    // ---------------- Lanes ----------------
    for (genvar l = 0; l < N_LANE; l++) begin : g_lane
        logic wr_sel;
        assign wr_sel = idle && wgt_wr && (int'(wgt_lane) == l);

        bpu_lane #(
            .K     (K),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wgt_wr  (wr_sel),
            .wgt_row (data_in[K-1:0]),
            .clr     (idle && start && !acc),
            .add     (run),
            .row_sel (row_q),
            .win     (win),
            .result  (result[l])
        );
    end

endmodule

// File: tb/tb_bpu_array.sv
module tb_bpu_array;

    localparam int N_LANE   = 8;
    localparam int K        = 7;
    localparam int IMG_W    = 8;
    localparam int IMG_ROWS = 16;
    localparam int DIN_W    = 8;
    localparam int ACC_W    = 12;
    localparam int LIM      = 1 << (ACC_W - 1);

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             en        = 1'b1;
    logic [DIN_W-1:0] data_in   = '0;
    logic             img_wr    = 1'b0;
    logic [0:0]       img_bank  = '0;
    logic             img_up    = 1'b0;
    logic             wgt_wr    = 1'b0;
    logic [2:0]       wgt_lane  = '0;
    logic             start     = 1'b0;
    logic             acc       = 1'b0;
    logic [0:0]       ofs       = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic             busy;
    logic signed [ACC_W-1:0] result [N_LANE];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bpu_array #(
        .N_LANE   (N_LANE),
        .K        (K),
        .IMG_W    (IMG_W),
        .IMG_ROWS (IMG_ROWS),
        .DIN_W    (DIN_W),
        .ACC_W    (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .img_wr    (img_wr),
        .img_bank  (img_bank),
        .img_up    (img_up),
        .wgt_wr    (wgt_wr),
        .wgt_lane  (wgt_lane),
        .start     (start),
        .acc       (acc),
        .ofs       (ofs),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .result    (result)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- Reference model ----------------
    logic [IMG_W-1:0] m_img [IMG_ROWS];
    logic [K-1:0]     m_w   [N_LANE][K];
    int               m_ptr [N_LANE];
    int               m_acc [N_LANE];
    bit               m_busy  = 1'b0;
    bit               m_valid = 1'b0;
    int               m_e     = 0;   // count of enabled clock edges
    int               m_t     = 0;   // enabled-edge index of the accepted start

    function automatic int acc_add(input int a, input int t);
        int v;
        v = a + t;
`ifdef BPU_ARRAY_SAT_EN
        if (v > LIM - 1) v = LIM - 1;
        if (v < -LIM)    v = -LIM;
`else
        if (v > LIM - 1) v -= 2 * LIM;
        if (v < -LIM)    v += 2 * LIM;
`endif
        return v;
    endfunction

    // +1 for each agreeing window/kernel bit, -1 for each disagreeing bit.
    function automatic int row_sum(input int l, input int r, input int o);
        int s;
        s = 0;
        for (int j = 0; j < K; j++) s += (m_img[r][o + j] == m_w[l][r][j]) ? 1 : -1;
        return s;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < IMG_ROWS; r++) m_img[r] = '0;
        for (int l = 0; l < N_LANE; l++) begin
            for (int r = 0; r < K; r++) m_w[l][r] = '0;
            m_ptr[l] = 0;
            m_acc[l] = 0;
        end
        m_busy  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic m_step();
        bit was_busy;
        int o;
        int row;
        if (rst) begin
            m_reset();
            return;
        end
        if (!en) return;
        m_e++;
        was_busy = m_busy;
        if (!was_busy) begin
            if (img_wr) begin
                for (int i = 0; i < DIN_W; i++) begin
                    row = int'(img_bank) * DIN_W + i;
                    if (row < IMG_ROWS) m_img[row] = {m_img[row][IMG_W-2:0], data_in[i]};
                end
            end else if (img_up) begin
                for (int r = 0; r < IMG_ROWS - 1; r++) m_img[r] = m_img[r + 1];
                m_img[IMG_ROWS-1] = '0;
            end
            if (wgt_wr && int'(wgt_lane) < N_LANE) begin
                m_w[wgt_lane][m_ptr[wgt_lane]] = data_in[K-1:0];
                m_ptr[wgt_lane] = (m_ptr[wgt_lane] + 1) % K;
            end
            if (start) begin
                o = (int'(ofs) > IMG_W - K) ? IMG_W - K : int'(ofs);
                m_busy = 1'b1;
                m_t    = m_e;
                for (int l = 0; l < N_LANE; l++) begin
                    if (!acc) m_acc[l] = 0;
                    for (int r = 0; r < K; r++) m_acc[l] = acc_add(m_acc[l], row_sum(l, r, o));
                end
            end
        end else if ((m_e - m_t > K) && out_ready) begin
            m_busy = 1'b0;
        end
        m_valid = m_busy && (m_e - m_t >= K);
    endtask

    // Compare process: step the model on every edge, then check the DUT.
    always @(posedge clk) begin
        #1;
        m_step();
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, m_valid);
        if (!m_busy || m_valid) begin
            for (int l = 0; l < N_LANE; l++)
                chk($sformatf("result[%0d]", l), result[l], m_acc[l]);
        end
    end

    // ---------------- Stimulus helpers (called at a falling edge) ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wgt_rows(input int l, input logic [DIN_W-1:0] v);
        for (int i = 0; i < K; i++) begin
            wgt_wr = 1'b1; wgt_lane = 3'(l); data_in = v;
            @(negedge clk);
        end
        wgt_wr = 1'b0;
    endtask

    task automatic img_fill(input logic [DIN_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            img_wr = 1'b1; img_bank = '0; data_in = v;
            @(negedge clk);
        end
        img_wr = 1'b0;
    endtask

    task automatic run_pass(input bit a, input int o, output int lat);
        start = 1'b1; acc = a; ofs = 1'(o); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("pass reaches out_valid", out_valid, 1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int lat;

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset busy", busy, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset result[0]", result[0], 0);

        // All-ones image; lane 0 kernel all ones, lane 1 all zeros.
        img_fill(8'hFF, 8);
        wgt_rows(0, 8'h7F);
        wgt_rows(1, 8'h00);
        run_pass(1'b0, 0, lat);
        chk("start-to-valid edges", lat, 7);
        chk("fresh lane0", result[0], 49);
        chk("fresh lane1", result[1], -49);

        // Stall in DONE with start held: nothing moves.
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall out_valid", out_valid, 1);
            chk("stall lane0", result[0], 49);
        end
        start = 1'b0;
        accept();
        chk("accepted busy", busy, 0);
        chk("accepted out_valid", out_valid, 0);

        run_pass(1'b1, 0, lat);
        chk("acc lane0", result[0], 98);
        chk("acc lane1", result[1], -98);
        accept();

        // 43 passes total of +/-49 push past the 12-bit range.
        for (int p = 0; p < 41; p++) begin
            run_pass(1'b1, 0, lat);
            accept();
        end
`ifdef BPU_ARRAY_SAT_EN
        chk("overflow lane0", result[0], 2047);
        chk("overflow lane1", result[1], -2048);
`else
        chk("overflow lane0", result[0], -1989);
        chk("overflow lane1", result[1], 1989);
`endif

        // Rows 0..6 = 8'b0000_0001 against an all-ones kernel.
        do_reset();
        wgt_rows(0, 8'h7F);
        img_fill(8'h7F, 1);
        run_pass(1'b0, 0, lat);
        chk("ofs0 lane0", result[0], -35);
        accept();
        run_pass(1'b0, 1, lat);
        chk("ofs1 lane0", result[0], -49);
        accept();

        // Reset in the middle of the row sweep.
        img_fill(8'hFF, 8);
        start = 1'b1; acc = 1'b0; ofs = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        chk("midrun rst busy", busy, 0);
        chk("midrun rst result[0]", result[0], 0);
        img_fill(8'hFF, 8);
        run_pass(1'b0, 0, lat);
        chk("cleared weights lane0", result[0], -49);
        accept();

        // Column write and row shift together: only the write happens.
        do_reset();
        wgt_rows(0, 8'h7F);
        img_wr = 1'b1; img_up = 1'b1; img_bank = '0; data_in = 8'h01;
        @(negedge clk);
        img_wr = 1'b0; img_up = 1'b0;
        run_pass(1'b0, 0, lat);
        chk("wr+up lane0", result[0], -47);
        accept();

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            en        = ($urandom_range(0, 7) != 0);
            data_in   = DIN_W'($urandom);
            img_wr    = ($urandom_range(0, 3) == 0);
            img_bank  = 1'($urandom_range(0, 1));
            img_up    = ($urandom_range(0, 5) == 0);
            wgt_wr    = ($urandom_range(0, 2) == 0);
            wgt_lane  = 3'($urandom_range(0, 7));
            start     = ($urandom_range(0, 3) == 0);
            acc       = 1'($urandom_range(0, 1));
            ofs       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        rst = 1'b0; en = 1'b1; img_wr = 1'b0; img_up = 1'b0; wgt_wr = 1'b0; start = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("drained busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
